// File: rtl/bip_cpu_param.sv
// Single-cycle accumulator CPU: one instruction per valid fetch, with stall,
// halt, branch and a saturating retired-instruction counter.
module bip_cpu_param #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned CNT_W  = 16,
    localparam int unsigned INSTR_W = 5 + ADDR_W
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [INSTR_W-1:0] INSTRUCTION,
    input  logic               PM_VALID,
    input  logic [DATA_W-1:0]  DM_IN,
    output logic [ADDR_W-1:0]  ADDR_PM,
    output logic [ADDR_W-1:0]  ADDR_DM,
    output logic [DATA_W-1:0]  ACC,
    output logic               RD,
    output logic               WR,
    output logic               WR_ACC,
    output logic               HALTED,
    output logic [CNT_W-1:0]   RETIRED
);

    typedef enum logic [4:0] {
        OP_HLT  = 5'b00000,
        OP_STO  = 5'b00001,
        OP_LD   = 5'b00010,
        OP_LDI  = 5'b00011,
        OP_ADD  = 5'b00100,
        OP_ADDI = 5'b00101,
        OP_SUB  = 5'b00110,
        OP_SUBI = 5'b00111,
        OP_AND  = 5'b01000,
        OP_OR   = 5'b01001,
        OP_XOR  = 5'b01010,
        OP_JMP  = 5'b01011,
        OP_BEQ  = 5'b01100,
        OP_BNE  = 5'b01101
    } opcode_t;

    opcode_t            opcode;
    logic [ADDR_W-1:0]  operand;
    logic [DATA_W-1:0]  imm;

    logic [ADDR_W-1:0]  pc;
    logic [DATA_W-1:0]  acc;
    logic               halted;
    logic [CNT_W-1:0]   retired;

    logic               issue;
    logic               rd_dec;
    logic               wr_dec;
    logic               wr_acc_dec;
    logic               halt_next;
    logic [ADDR_W-1:0]  pc_plus1;
    logic [ADDR_W-1:0]  pc_next;
    logic [DATA_W-1:0]  acc_next;

    assign opcode   = opcode_t'(INSTRUCTION[INSTR_W-1:ADDR_W]);
    assign operand  = INSTRUCTION[ADDR_W-1:0];
    assign pc_plus1 = pc + ADDR_W'(1);

    generate
        if (ADDR_W >= DATA_W) begin : g_imm_trunc
            assign imm = operand[DATA_W-1:0];
        end else begin : g_imm_sext
            assign imm = {{(DATA_W-ADDR_W){operand[ADDR_W-1]}}, operand};
        end
    endgenerate

    // RESET in the issue term also forces the strobes low while reset is held.
    assign issue = RESET && PM_VALID && !halted;

    always_comb begin
        rd_dec     = 1'b0;
        wr_dec     = 1'b0;
        wr_acc_dec = 1'b0;
        halt_next  = 1'b0;
        pc_next    = pc_plus1;
        acc_next   = acc;
        case (opcode)
            OP_HLT: begin
                halt_next = 1'b1;
                pc_next   = pc;
            end
            OP_STO:  wr_dec = 1'b1;
            OP_LD: begin
                rd_dec     = 1'b1;
                wr_acc_dec = 1'b1;
                acc_next   = DM_IN;
            end
            OP_LDI: begin
                wr_acc_dec = 1'b1;
                acc_next   = imm;
            end
            OP_ADD: begin
                rd_dec     = 1'b1;
                wr_acc_dec = 1'b1;
                acc_next   = acc + DM_IN;
            end
            OP_ADDI: begin
                wr_acc_dec = 1'b1;
                acc_next   = acc + imm;
            end
            OP_SUB: begin
                rd_dec     = 1'b1;
                wr_acc_dec = 1'b1;
                acc_next   = acc - DM_IN;
            end
            OP_SUBI: begin
                wr_acc_dec = 1'b1;
                acc_next   = acc - imm;
            end
            OP_AND: begin
                rd_dec     = 1'b1;
                wr_acc_dec = 1'b1;
                acc_next   = acc & DM_IN;
            end
            OP_OR: begin
                rd_dec     = 1'b1;
                wr_acc_dec = 1'b1;
                acc_next   = acc | DM_IN;
            end
            OP_XOR: begin
                rd_dec     = 1'b1;
                wr_acc_dec = 1'b1;
                acc_next   = acc ^ DM_IN;
            end
            OP_JMP:  pc_next = operand;
            OP_BEQ:  pc_next = (acc == '0) ? operand : pc_plus1;
            OP_BNE:  pc_next = (acc != '0) ? operand : pc_plus1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc      <= '0;
            acc     <= '0;
            halted  <= 1'b0;
            retired <= '0;
        end else if (issue) begin
            pc     <= pc_next;
            acc    <= acc_next;
            halted <= halt_next;
            if (retired != '1)
                retired <= retired + CNT_W'(1);
        end
    end

    assign ADDR_PM = pc;
    assign ADDR_DM = operand;
    assign ACC     = acc;
    assign RD      = issue && rd_dec;
    assign WR      = issue && wr_dec;
    assign WR_ACC  = issue && wr_acc_dec;
    assign HALTED  = halted;
    assign RETIRED = retired;

endmodule

// File: tb/tb_bip_cpu_param.sv
// Directed bench for bip_cpu_param: table-driven program plus halt, reset,
// branch, stall, PC-wrap and counter-saturation sequences.
module tb_bip_cpu_param;

    logic        clk;
    logic        rst_n;
    logic [15:0] instruction;
    logic        pm_valid;
    logic [15:0] dm_in;
    logic [10:0] addr_pm;
    logic [10:0] addr_dm;
    logic [15:0] acc;
    logic        rd;
    logic        wr;
    logic        wr_acc;
    logic        halted;
    logic [15:0] retired;

    logic [10:0] addr_pm2;
    logic [10:0] addr_dm2;
    logic [15:0] acc2;
    logic        rd2;
    logic        wr2;
    logic        wr_acc2;
    logic        halted2;
    logic [1:0]  retired2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem [0:2047];
    logic        mem_load;

    bip_cpu_param #(.DATA_W(16), .ADDR_W(11), .CNT_W(16)) dut (
        .CLK(clk), .RESET(rst_n), .INSTRUCTION(instruction), .PM_VALID(pm_valid),
        .DM_IN(dm_in), .ADDR_PM(addr_pm), .ADDR_DM(addr_dm), .ACC(acc),
        .RD(rd), .WR(wr), .WR_ACC(wr_acc), .HALTED(halted), .RETIRED(retired)
    );

    bip_cpu_param #(.DATA_W(16), .ADDR_W(11), .CNT_W(2)) dut_sat (
        .CLK(clk), .RESET(rst_n), .INSTRUCTION(instruction), .PM_VALID(pm_valid),
        .DM_IN(dm_in), .ADDR_PM(addr_pm2), .ADDR_DM(addr_dm2), .ACC(acc2),
        .RD(rd2), .WR(wr2), .WR_ACC(wr_acc2), .HALTED(halted2), .RETIRED(retired2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_in = mem[addr_dm];

    always @(posedge clk) begin
        if (mem_load) begin
            mem[2] <= 16'hFFFF;
            mem[3] <= 16'h0000;
            mem[4] <= 16'h00F0;
            mem[5] <= 16'h0F0F;
            mem[6] <= 16'h1234;
        end else if (wr) begin
            mem[addr_dm] <= acc;
        end
    end

    localparam logic [4:0] HLT = 5'd0, STO = 5'd1, LD = 5'd2, LDI = 5'd3, ADD = 5'd4,
                           ADDI = 5'd5, SUB = 5'd6, SUBI = 5'd7, AND_ = 5'd8, OR_ = 5'd9,
                           XOR_ = 5'd10, JMP = 5'd11, BEQ = 5'd12, BNE = 5'd13,
                           NOP = 5'd14, NOP31 = 5'd31;

    function automatic logic [15:0] mk(input logic [4:0] op, input logic [10:0] opnd);
        return {op, opnd};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one instruction on a falling edge, check strobes, then the post-edge state.
    task automatic exec(input logic [15:0] ins, input bit erd, input bit ewr, input bit ewa,
                        input logic [15:0] eacc, input logic [10:0] epc);
        @(negedge clk);
        instruction = ins;
        pm_valid    = 1'b1;
        #1;
        chk("rd", {31'd0, rd}, {31'd0, erd});
        chk("wr", {31'd0, wr}, {31'd0, ewr});
        chk("wr_acc", {31'd0, wr_acc}, {31'd0, ewa});
        @(posedge clk);
        #1;
        chk("acc", {16'd0, acc}, {16'd0, eacc});
        chk("pc", {21'd0, addr_pm}, {21'd0, epc});
    endtask

    task automatic do_reset;
        @(negedge clk);
        pm_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        rst_n    = 1'b1;
    endtask

    typedef struct {
        logic [15:0] ins;
        bit          rd;
        bit          wr;
        bit          wa;
        logic [15:0] acc;
        logic [10:0] pc;
    } vec_t;

    vec_t tbl [19];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0]  = '{mk(LDI,  11'h005), 0, 0, 1, 16'h0005, 11'h001};
        tbl[1]  = '{mk(ADDI, 11'h7F9), 0, 0, 1, 16'hFFFE, 11'h002};
        tbl[2]  = '{mk(STO,  11'h003), 0, 1, 0, 16'hFFFE, 11'h003};
        tbl[3]  = '{mk(LD,   11'h006), 1, 0, 1, 16'h1234, 11'h004};
        tbl[4]  = '{mk(AND_, 11'h005), 1, 0, 1, 16'h0204, 11'h005};
        tbl[5]  = '{mk(OR_,  11'h004), 1, 0, 1, 16'h02F4, 11'h006};
        tbl[6]  = '{mk(XOR_, 11'h005), 1, 0, 1, 16'h0DFB, 11'h007};
        tbl[7]  = '{mk(SUB,  11'h003), 1, 0, 1, 16'h0DFD, 11'h008};
        tbl[8]  = '{mk(SUBI, 11'h3FF), 0, 0, 1, 16'h09FE, 11'h009};
        tbl[9]  = '{mk(LDI,  11'h400), 0, 0, 1, 16'hFC00, 11'h00A};
        tbl[10] = '{mk(ADDI, 11'h3FF), 0, 0, 1, 16'hFFFF, 11'h00B};
        tbl[11] = '{mk(ADD,  11'h002), 1, 0, 1, 16'hFFFE, 11'h00C};
        tbl[12] = '{mk(NOP31,11'h002), 0, 0, 0, 16'hFFFE, 11'h00D};
        tbl[13] = '{mk(JMP,  11'h100), 0, 0, 0, 16'hFFFE, 11'h100};
        tbl[14] = '{mk(BNE,  11'h050), 0, 0, 0, 16'hFFFE, 11'h050};
        tbl[15] = '{mk(BEQ,  11'h060), 0, 0, 0, 16'hFFFE, 11'h051};
        tbl[16] = '{mk(LDI,  11'h000), 0, 0, 1, 16'h0000, 11'h052};
        tbl[17] = '{mk(BEQ,  11'h060), 0, 0, 0, 16'h0000, 11'h060};
        tbl[18] = '{mk(BNE,  11'h070), 0, 0, 0, 16'h0000, 11'h061};

        instruction = '0;
        pm_valid    = 1'b0;
        mem_load    = 1'b1;
        rst_n       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mem_load = 1'b0;
        chk("reset_pc", {21'd0, addr_pm}, 32'd0);
        chk("reset_acc", {16'd0, acc}, 32'd0);
        chk("reset_halted", {31'd0, halted}, 32'd0);
        chk("reset_retired", {16'd0, retired}, 32'd0);
        do_reset;

        foreach (tbl[i])
            exec(tbl[i].ins, tbl[i].rd, tbl[i].wr, tbl[i].wa, tbl[i].acc, tbl[i].pc);
        chk("tbl_mem3", {16'd0, mem[3]}, 32'h0000_FFFE);
        chk("tbl_retired", {16'd0, retired}, 32'd19);

        // LDI 5; ADDI -7; STO 3; HLT
        do_reset;
        exec(mk(LDI,  11'h005), 0, 0, 1, 16'h0005, 11'h001);
        exec(mk(ADDI, 11'h7F9), 0, 0, 1, 16'hFFFE, 11'h002);
        exec(mk(STO,  11'h003), 0, 1, 0, 16'hFFFE, 11'h003);
        exec(mk(HLT,  11'h000), 0, 0, 0, 16'hFFFE, 11'h003);
        chk("halt_flag", {31'd0, halted}, 32'd1);
        chk("halt_retired", {16'd0, retired}, 32'd4);
        chk("halt_mem3", {16'd0, mem[3]}, 32'h0000_FFFE);
        exec(mk(LDI, 11'h009), 0, 0, 0, 16'hFFFE, 11'h003);
        exec(mk(STO, 11'h004), 0, 0, 0, 16'hFFFE, 11'h003);
        chk("halt_hold_retired", {16'd0, retired}, 32'd4);
        chk("halt_hold_flag", {31'd0, halted}, 32'd1);

        // Asynchronous reset pulse between edges while halted
        @(negedge clk);
        instruction = mk(LDI, 11'h007);
        pm_valid    = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", {21'd0, addr_pm}, 32'd0);
        chk("arst_acc", {16'd0, acc}, 32'd0);
        chk("arst_halted", {31'd0, halted}, 32'd0);
        chk("arst_retired", {16'd0, retired}, 32'd0);
        chk("arst_wr_acc", {31'd0, wr_acc}, 32'd0);
        #1;
        rst_n = 1'b1;
        #1;
        chk("resume_fetch_addr", {21'd0, addr_pm}, 32'd0);
        @(posedge clk);
        #1;
        chk("resume_acc", {16'd0, acc}, 32'd7);
        chk("resume_pc", {21'd0, addr_pm}, 32'd1);

        // Branches, then ADD wrap with RD
        do_reset;
        exec(mk(LDI, 11'h000), 0, 0, 1, 16'h0000, 11'd1);
        exec(mk(BEQ, 11'd10),  0, 0, 0, 16'h0000, 11'd10);
        exec(mk(LDI, 11'h001), 0, 0, 1, 16'h0001, 11'd11);
        exec(mk(BNE, 11'd20),  0, 0, 0, 16'h0001, 11'd20);
        exec(mk(LDI, 11'h001), 0, 0, 1, 16'h0001, 11'd21);
        exec(mk(BEQ, 11'd10),  0, 0, 0, 16'h0001, 11'd22);
        exec(mk(LDI, 11'h001), 0, 0, 1, 16'h0001, 11'd23);
        exec(mk(ADD, 11'h002), 1, 0, 1, 16'h0000, 11'd24);

        // Stall: strobes low, state held for 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            instruction = (i == 0) ? mk(STO, 11'h005) : mk(ADD, 11'h002);
            pm_valid    = 1'b0;
            #1;
            chk("stall_rd", {31'd0, rd}, 32'd0);
            chk("stall_wr", {31'd0, wr}, 32'd0);
            chk("stall_wr_acc", {31'd0, wr_acc}, 32'd0);
            @(posedge clk);
            #1;
            chk("stall_pc", {21'd0, addr_pm}, 32'd24);
            chk("stall_acc", {16'd0, acc}, 32'd0);
            chk("stall_retired", {16'd0, retired}, 32'd8);
        end

        // PC wrap from 0x7FF
        exec(mk(JMP, 11'h7FF), 0, 0, 0, 16'h0000, 11'h7FF);
        exec(mk(NOP, 11'h123), 0, 0, 0, 16'h0000, 11'h000);

        // Counter saturation on the CNT_W=2 instance
        do_reset;
        for (int i = 0; i < 5; i++)
            exec(mk(NOP, 11'h000), 0, 0, 0, 16'h0000, 11'(i + 1));
        chk("sat_retired_cnt2", {30'd0, retired2}, 32'd3);
        chk("sat_retired_cnt16", {16'd0, retired}, 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bip_cpu_param.md
BIP_CPU_PARAM -- requirements
Module: bip_cpu_param

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the accumulator, data-memory and arithmetic width.
REQ-002 Parameter ADDR_W, default 11, SHALL set the PC, program-address, data-address and operand width.
REQ-003 Parameter CNT_W, default 16, SHALL set the retired-instruction counter width.
REQ-004 Derived constant INSTR_W = 5 + ADDR_W SHALL be the instruction width: opcode in [INSTR_W-1:ADDR_W], operand in [ADDR_W-1:0].
REQ-005 Ports SHALL be:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- INSTRUCTION  in  INSTR_W  program-memory word addressed by ADDR_PM.
- PM_VALID  in  1  INSTRUCTION is valid this cycle; 0 stalls the core.
- DM_IN  in  DATA_W  data-memory read data, combinational from ADDR_DM.
- ADDR_PM  out  ADDR_W  current PC.
- ADDR_DM  out  ADDR_W  operand field; meaningful only when RD or WR is 1.
- ACC  out  DATA_W  accumulator; also the data-memory write data.
- RD  out  1  data-memory read strobe.
- WR  out  1  data-memory write strobe.
- WR_ACC  out  1  accumulator update this cycle.
- HALTED  out  1  core is halted.
- RETIRED  out  CNT_W  retired-instruction count.

Function
REQ-006 An instruction SHALL issue and complete in one cycle when PM_VALID=1 and HALTED=0; ACC, PC and RETIRED SHALL update on that rising edge.
REQ-007 Opcode set SHALL be: 00000 HLT; 00001 STO (MEM[op]<=ACC); 00010 LD (ACC<=MEM[op]); 00011 LDI (ACC<=imm); 00100 ADD; 00101 ADDI; 00110 SUB; 00111 SUBI; 01000 AND; 01001 OR; 01010 XOR (each ALU op uses ACC and MEM[op]); 01011 JMP; 01100 BEQ; 01101 BNE.
REQ-008 Opcodes 01110 to 11111 SHALL execute as NOP: PC+1, no strobes, and the instruction counts as retired.
REQ-009 imm SHALL be the operand sign-extended to DATA_W; if ADDR_W >= DATA_W, the low DATA_W bits SHALL be used.
REQ-010 ADD and SUB results SHALL wrap modulo 2^DATA_W, with no carry or overflow state.
REQ-011 RD SHALL be 1 only for LD, ADD, SUB, AND, OR and XOR; WR SHALL be 1 only for STO; WR_ACC SHALL be 1 for LD, LDI, ADD, ADDI, SUB, SUBI, AND, OR and XOR; all three are combinational from the opcode.
REQ-012 JMP SHALL load PC<=operand.
REQ-013 BEQ SHALL load PC<=operand if ACC==0, otherwise PC+1; BNE SHALL do the inverse. The test SHALL use ACC before the edge.
REQ-014 PC+1 SHALL wrap from 2^ADDR_W-1 to 0.
REQ-015 Stall: when PM_VALID=0, RD, WR and WR_ACC SHALL be 0, and PC, ACC and RETIRED SHALL hold.
REQ-016 HLT SHALL set HALTED at the next edge, hold PC at the HLT address and increment RETIRED once.
REQ-017 While HALTED=1, RD, WR and WR_ACC SHALL be 0 and all state SHALL hold; only reset exits the halted state.
REQ-018 RETIRED SHALL increment once per issued instruction and SHALL saturate at 2^CNT_W-1.

Reset
REQ-019 RESET=0 SHALL asynchronously clear PC, ACC, HALTED and RETIRED to 0, whether mid-stall or mid-halt.
REQ-020 While RESET=0, RD, WR and WR_ACC SHALL be forced to 0.
REQ-021 The first issue after reset SHALL occur at the first rising edge with RESET=1 and PM_VALID=1, fetching address 0.

Verification
REQ-022 The bench SHALL cover the following directed scenarios:
- Program LDI 5; ADDI -7; STO 3; HLT -> ACC=0xFFFE, MEM[3]=0xFFFE, HALTED=1, PC=3, RETIRED=4.
- LDI 0; BEQ 10 -> PC=10. LDI 1; BNE 20 -> PC=20. LDI 1; BEQ 10 -> PC=next sequential address.
- MEM[2]=0xFFFF; LDI 1; ADD 2 -> ACC=0x0000, with RD=1 on the ADD cycle.
- PM_VALID held 0 for 3 cycles mid-program -> PC, ACC and RETIRED unchanged, and no strobes.
- PC=0x7FF (ADDR_W=11) executing NOP -> PC=0x000; CNT_W=2 after 5 instructions -> RETIRED=3.
- RESET pulsed low between edges while halted -> PC=0, ACC=0, HALTED=0 and RETIRED=0 immediately; execution resumes at address 0.
